// File: rtl/counter_cmd_sequencer_pkg.sv
// Shared types for the counter command sequencer: op codes and FSM states.
package counter_seq_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD      = 3'd0,
        OP_STEP_UP   = 3'd1,
        OP_STEP_DOWN = 3'd2,
        OP_RUN_MAX   = 3'd3,
        OP_RUN_ZERO  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STEP,
        RUN
    } state_e;

endpackage

// File: rtl/counter_cmd_sequencer_if.sv
// Command handshake bus between an issuer (master) and the sequencer (slave).
interface counter_cmd_sequencer_if #(parameter int unsigned WIDTH = 4);
    import counter_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [WIDTH-1:0]  cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/counter_cmd_sequencer.sv
// Turns op+argument commands into cycle-by-cycle load/step/run control of an
// up/down loadable counter, pulsing done on normal completion and err on bad ops.
module counter_cmd_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    counter_cmd_sequencer_if.slave   cmd,
    input  logic                     abort,
    input  logic                     max_count,
    input  logic                     zero,
    output logic                     load_n,
    output logic                     up_down,
    output logic                     ce,
    output logic [WIDTH-1:0]         data_load,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] dl_q, dl_d;
    logic             up_q, up_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept;
    logic             limit;

    assign cmd.cmd_ready = (state_q == IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    // RUN direction is remembered in up_q, so it also selects which flag ends the run.
    assign limit         = up_q ? max_count : zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            dl_q    <= '0;
            up_q    <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dl_q    <= dl_d;
            up_q    <= up_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dl_d    = dl_q;
        up_d    = up_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load_n  = 1'b1;
        ce      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_LOAD: begin
                            dl_d    = cmd.cmd_arg;
                            state_d = LOAD;
                        end
                        OP_STEP_UP, OP_STEP_DOWN: begin
                            up_d   = (cmd.cmd_op == OP_STEP_UP);
                            step_d = cmd.cmd_arg;
                            // A zero-length step completes straight from IDLE.
                            if (cmd.cmd_arg == '0) done_d  = 1'b1;
                            else                   state_d = STEP;
                        end
                        OP_RUN_MAX: begin
                            up_d    = 1'b1;
                            state_d = RUN;
                        end
                        OP_RUN_ZERO: begin
                            up_d    = 1'b0;
                            state_d = RUN;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            LOAD: begin
                load_n  = abort;
                done_d  = ~abort;
                state_d = IDLE;
            end
            STEP: begin
                ce = ~abort;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    step_d = step_q - 1'b1;
                    if (step_q == WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RUN: begin
                ce = ~limit & ~abort;
                if (abort) begin
                    state_d = IDLE;
                end else if (limit) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign up_down   = up_q;
    assign data_load = dl_q;
    assign busy      = ~cmd.cmd_ready;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench: a behavioural 4-bit counter closes the loop around the sequencer.
module tb_counter_cmd_sequencer;
    import counter_seq_pkg::*;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             abort = 1'b0;
    logic             max_count, zero;
    logic             load_n, up_down, ce, busy, done, err;
    logic [WIDTH-1:0] data_load;
    logic [WIDTH-1:0] cnt;

    int checks = 0;
    int failures = 0;

    counter_cmd_sequencer_if #(.WIDTH(WIDTH)) cif ();

    counter_cmd_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cif),
        .abort     (abort),
        .max_count (max_count),
        .zero      (zero),
        .load_n    (load_n),
        .up_down   (up_down),
        .ce        (ce),
        .data_load (data_load),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Counter being controlled: load has priority over count enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt <= '0;
        else if (!load_n) cnt <= data_load;
        else if (ce)      cnt <= up_down ? cnt + 1'b1 : cnt - 1'b1;
    end
    assign max_count = (cnt == 4'hF);
    assign zero      = (cnt == 4'h0);

    task automatic send_cmd(input logic [2:0] op, input logic [WIDTH-1:0] arg);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_arg   = arg;
        @(negedge clk);
        cif.cmd_valid = 1'b0;
    endtask

    // Watch from the current negedge until cmd_ready returns (bounded).
    task automatic observe(output int ce_cnt, output int ld_cnt, output int cyc,
                           output bit done_seen, output bit err_seen, output bit timeout);
        ce_cnt = 0; ld_cnt = 0; cyc = 0;
        done_seen = 1'b0; err_seen = 1'b0; timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (cif.cmd_ready) begin
                done_seen = done;
                err_seen  = err;
                timeout   = 1'b0;
                break;
            end
            ce_cnt += int'(ce);
            ld_cnt += int'(!load_n);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++; if (cif.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b expected 1", cif.cmd_ready); end
        checks++; if ({load_n, ce, up_down, busy, done, err} !== 6'b101000) begin
            failures++; $display("FAIL rst_pins: got %b expected 101000", {load_n, ce, up_down, busy, done, err}); end
        checks++; if (data_load !== 4'h0) begin failures++; $display("FAIL rst_data_load: got %h expected 0", data_load); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_step();
        int n = 0;
        send_cmd(OP_STEP_UP, 4'd9);
        for (int i = 0; i < 20; i++) begin
            if (ce) n++;
            if (n == 4) break;
            @(negedge clk);
        end
        checks++; if (n != 4) begin failures++; $display("FAIL midrst_ce_count: got %0d expected 4", n); end
        rst = 1'b1;
        #1;
        checks++; if (ce !== 1'b0) begin failures++; $display("FAIL midrst_ce: got %b expected 0", ce); end
        checks++; if (cif.cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b expected 1", cif.cmd_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", done); end
        end
    endtask

    task automatic test_load();
        send_cmd(OP_LOAD, 4'hA);
        checks++; if (load_n !== 1'b0 || data_load !== 4'hA) begin
            failures++; $display("FAIL load_pins: got load_n=%b data=%h expected 0/a", load_n, data_load); end
        checks++; if (cif.cmd_ready !== 1'b0) begin failures++; $display("FAIL load_busy: got ready=%b expected 0", cif.cmd_ready); end
        @(negedge clk);
        checks++; if (load_n !== 1'b1) begin failures++; $display("FAIL load_once: got load_n=%b expected 1", load_n); end
        checks++; if (done !== 1'b1 || cif.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL load_done: got done=%b ready=%b expected 1/1", done, cif.cmd_ready); end
        checks++; if (cnt !== 4'hA) begin failures++; $display("FAIL load_count: got %h expected a", cnt); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL load_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_back_to_back();
        int ce_cnt, ld_cnt, cyc; bit d, e, to;
        cif.cmd_valid = 1'b1; cif.cmd_op = OP_LOAD; cif.cmd_arg = 4'hD;
        @(negedge clk);
        cif.cmd_op = OP_STEP_UP; cif.cmd_arg = 4'd5;
        @(negedge clk);
        checks++; if (done !== 1'b1 || cif.cmd_ready !== 1'b1 || cnt !== 4'hD) begin
            failures++; $display("FAIL b2b_load_done: got done=%b ready=%b cnt=%h expected 1/1/d", done, cif.cmd_ready, cnt); end
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        checks++; if (ce !== 1'b1 || up_down !== 1'b1) begin
            failures++; $display("FAIL b2b_gap: got ce=%b up=%b expected 1/1", ce, up_down); end
        observe(ce_cnt, ld_cnt, cyc, d, e, to);
        checks++; if (to || ce_cnt != 5 || cyc != 5 || !d) begin
            failures++; $display("FAIL b2b_step: got ce=%0d cyc=%0d done=%b timeout=%b expected 5/5/1/0", ce_cnt, cyc, d, to); end
        checks++; if (cnt !== 4'h2) begin failures++; $display("FAIL b2b_wrap: got %h expected 2", cnt); end
        @(negedge clk);
    endtask

    task automatic test_step_down_wrap();
        int ce_cnt, ld_cnt, cyc; bit d, e, to;
        send_cmd(OP_LOAD, 4'h1);
        observe(ce_cnt, ld_cnt, cyc, d, e, to);
        @(negedge clk);
        send_cmd(OP_STEP_DOWN, 4'd3);
        checks++; if (up_down !== 1'b0) begin failures++; $display("FAIL stepdn_dir: got %b expected 0", up_down); end
        observe(ce_cnt, ld_cnt, cyc, d, e, to);
        checks++; if (to || ce_cnt != 3 || !d || cnt !== 4'hE) begin
            failures++; $display("FAIL stepdn: got ce=%0d done=%b cnt=%h expected 3/1/e", ce_cnt, d, cnt); end
        @(negedge clk);
        checks++; if (up_down !== 1'b0) begin failures++; $display("FAIL stepdn_hold: got %b expected 0", up_down); end
    endtask

    task automatic test_run();
        int ce_cnt, ld_cnt, cyc; bit d, e, to;
        send_cmd(OP_LOAD, 4'h3);
        observe(ce_cnt, ld_cnt, cyc, d, e, to);
        @(negedge clk);
        send_cmd(OP_RUN_ZERO, 4'h0);
        checks++; if (up_down !== 1'b0 || ce !== 1'b1) begin
            failures++; $display("FAIL runz_start: got up=%b ce=%b expected 0/1", up_down, ce); end
        observe(ce_cnt, ld_cnt, cyc, d, e, to);
        checks++; if (to || ce_cnt != 3 || cyc != 4 || !d || cnt !== 4'h0) begin
            failures++; $display("FAIL runz: got ce=%0d cyc=%0d done=%b cnt=%h expected 3/4/1/0", ce_cnt, cyc, d, cnt); end
        @(negedge clk);
        send_cmd(OP_LOAD, 4'hF);
        observe(ce_cnt, ld_cnt, cyc, d, e, to);
        @(negedge clk);
        send_cmd(OP_RUN_MAX, 4'h0);
        observe(ce_cnt, ld_cnt, cyc, d, e, to);
        checks++; if (to || ce_cnt != 0 || cyc != 1 || !d || cnt !== 4'hF) begin
            failures++; $display("FAIL runmax_at_max: got ce=%0d cyc=%0d done=%b cnt=%h expected 0/1/1/f", ce_cnt, cyc, d, cnt); end
        @(negedge clk);
    endtask

    task automatic test_zero_step_and_err();
        int ce_cnt, ld_cnt, cyc; bit d, e, to;
        send_cmd(OP_STEP_DOWN, 4'd0);
        checks++; if (done !== 1'b1 || cif.cmd_ready !== 1'b1 || ce !== 1'b0) begin
            failures++; $display("FAIL step0: got done=%b ready=%b ce=%b expected 1/1/0", done, cif.cmd_ready, ce); end
        @(negedge clk);
        send_cmd(3'd6, 4'h7);
        observe(ce_cnt, ld_cnt, cyc, d, e, to);
        checks++; if (to || cyc != 0 || !e || d || ld_cnt != 0 || ce_cnt != 0) begin
            failures++; $display("FAIL bad_op: got cyc=%0d err=%b done=%b ld=%0d ce=%0d expected 0/1/0/0/0", cyc, e, d, ld_cnt, ce_cnt); end
        checks++; if (load_n !== 1'b1 || cnt !== 4'hF) begin
            failures++; $display("FAIL bad_op_pins: got load_n=%b cnt=%h expected 1/f", load_n, cnt); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pulse: got %b expected 0", err); end
    endtask

    task automatic test_abort();
        int ce_cnt, ld_cnt, cyc; bit d, e, to;
        int n = 0;
        send_cmd(OP_LOAD, 4'h0);
        observe(ce_cnt, ld_cnt, cyc, d, e, to);
        @(negedge clk);
        send_cmd(OP_RUN_MAX, 4'h0);
        for (int i = 0; i < 10; i++) begin
            if (ce) n++;
            if (n == 2) break;
            @(negedge clk);
        end
        @(negedge clk);
        abort = 1'b1;
        #1;
        checks++; if (ce !== 1'b0 || load_n !== 1'b1) begin
            failures++; $display("FAIL abort_pins: got ce=%b load_n=%b expected 0/1", ce, load_n); end
        @(negedge clk);
        abort = 1'b0;
        checks++; if (cif.cmd_ready !== 1'b1 || done !== 1'b0 || cnt !== 4'h2) begin
            failures++; $display("FAIL abort_end: got ready=%b done=%b cnt=%h expected 1/0/2", cif.cmd_ready, done, cnt); end
        send_cmd(OP_LOAD, 4'h5);
        checks++; if (load_n !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL abort_next_cmd: got load_n=%b busy=%b expected 0/1", load_n, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || cnt !== 4'h5) begin
            failures++; $display("FAIL abort_next_done: got done=%b cnt=%h expected 1/5", done, cnt); end
        @(negedge clk);
    endtask

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = '0;
        cif.cmd_arg   = '0;
        @(negedge clk);
        test_reset();
        test_reset_mid_step();
        test_load();
        test_back_to_back();
        test_step_down_wrap();
        test_run();
        test_zero_step_and_err();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
